ex_mem_pipe_reg: RTL

Parametrised EX/MEM pipeline stage register with valid/ready flow control, a two-entry skid buffer, synchronous flush and bubble insertion. It carries the EX-stage results (WB and M control bits, jump address, ALU status, ALU result, store data, destination register) into the MEM stage. It replaces the fixed-width, free-running stage register. Downstream may stall without a combinational ready path back into EX, and control hazards may squash in-flight instructions.

---
 rtl/ex_mem_pipe_reg.sv | 101 ++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/MEM stage register with two-entry skid buffer, flush and bubble gating
// The main entry drives MEM. The skid entry absorbs one beat, so in_ready never depends on out_ready.
module ex_mem_pipe_reg #(
  parameter int WB_W    = 2,
  parameter int M_W     = 3,
  parameter int JADDR_W = 8,
  parameter int STAT_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WB_W-1:0]    in_WB,
  input  logic [M_W-1:0]     in_M,
  input  logic [JADDR_W-1:0] in_jump_address,
  input  logic [STAT_W-1:0]  in_ALU_status,
  input  logic [DATA_W-1:0]  in_ALU_result,
  input  logic [DATA_W-1:0]  in_write_data,
  input  logic [RADDR_W-1:0] in_RegDst_address,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WB_W-1:0]    out_WB,
  output logic [M_W-1:0]     out_M,
  output logic [JADDR_W-1:0] out_jump_address,
  output logic [STAT_W-1:0]  out_ALU_status,
  output logic [DATA_W-1:0]  out_ALU_result,
  output logic [DATA_W-1:0]  out_write_data,
  output logic [RADDR_W-1:0] out_RegDst_address,
  output logic [1:0]         occupancy
);

  localparam int PW = WB_W + M_W + JADDR_W + STAT_W + 2 * DATA_W + RADDR_W;

  logic [PW-1:0]   main_q, main_d, skid_q, skid_d, in_beat;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic            in_fire, out_fire;
  logic [WB_W-1:0] main_wb;
  logic [M_W-1:0]  main_m;

  assign in_beat   = {in_WB, in_M, in_jump_address, in_ALU_status,
                      in_ALU_result, in_write_data, in_RegDst_address};
  assign in_ready  = ~rst & ~skid_valid_q;
  assign out_valid = ~rst & main_valid_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (in_fire && out_fire) begin
        main_d = in_beat;
      end else if (in_fire) begin
        skid_d       = in_beat;
        skid_valid_d = 1'b1;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      main_d       = in_beat;
      main_valid_d = 1'b1;
    end
  end

  // Flush holds the payload registers so a squashed beat never lands in main.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign {main_wb, main_m, out_jump_address, out_ALU_status,
          out_ALU_result, out_write_data, out_RegDst_address} = main_q;

  // An empty stage must look like a NOP to MEM.
  assign out_WB    = out_valid ? main_wb : '0;
  assign out_M     = out_valid ? main_m  : '0;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
